// File: rtl/load_sequencer.sv
// Splits a byte-addressed load command into AXI-sized read transactions with a bounded in-flight count.
// Optional build macro LOAD_SEQ_4K_BOUNDARY_EN keeps every transaction inside one 4 KiB page.
module load_sequencer #(
    parameter int AxiDataWidth   = 512,
    parameter int AxiAddrWidth   = 64,
    parameter int MaxBurstBeats  = 16,
    parameter int MaxOutstanding = 4,
    parameter int LenWidth       = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]     req_nbytes_i,
    output logic                    meta_valid_o,
    input  logic                    meta_ready_i,
    output logic                    txn_valid_o,
    input  logic                    txn_ready_i,
    output logic [AxiAddrWidth-1:0] txn_addr_o,
    output logic [7:0]              txn_len_o,
    output logic [LenWidth-1:0]     txn_nbytes_o,
    output logic                    txn_last_o,
    input  logic                    txn_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [1:0]              dbg_state_o
);

    localparam int BB  = AxiDataWidth / 8;
    localparam int BBW = $clog2(BB);
    localparam int CW  = LenWidth + 1;
    localparam int OW  = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] BURST_BYTES = CW'(MaxBurstBeats * BB);
    localparam logic [OW-1:0] MAX_OUT     = OW'(MaxOutstanding);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_META  = 2'd1,
        S_SPLIT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    logic [AxiAddrWidth-1:0] r_cur_addr;
    logic [LenWidth-1:0]     r_remaining;
    logic [OW-1:0]           r_outstanding;
    logic                    r_busy;
    logic                    r_meta_valid;
    logic                    r_done;

    logic [CW-1:0] w_off;
    logic [CW-1:0] w_rem;
    logic [CW-1:0] w_lim;
    logic [CW-1:0] w_lim_eff;
    logic [CW-1:0] w_chunk;
    logic [CW-1:0] w_beats;
    logic [7:0]    w_len;
    logic          w_in_split;
    logic          w_last;
    logic          w_txn_fire;
    logic          w_done_dec;
    logic [OW-1:0] w_out_next;

    // Chunk math runs one bit wider than the byte count so the min() compare never sees a wrapped value.
    assign w_off = CW'(r_cur_addr[BBW-1:0]);
    assign w_rem = {1'b0, r_remaining};
    assign w_lim = BURST_BYTES - w_off;

`ifdef LOAD_SEQ_4K_BOUNDARY_EN
    logic [CW-1:0] w_lim_4k;
    assign w_lim_4k  = CW'(13'd4096) - CW'(r_cur_addr[11:0]);
    assign w_lim_eff = (w_lim_4k < w_lim) ? w_lim_4k : w_lim;
`else
    assign w_lim_eff = w_lim;
`endif

    assign w_chunk = (w_rem < w_lim_eff) ? w_rem : w_lim_eff;
    assign w_beats = (w_off + w_chunk + CW'(BB - 1)) >> BBW;
    assign w_len   = 8'(w_beats - CW'(1));
    assign w_last  = (w_chunk == w_rem);

    // Fields derive only from registers that hold while a transaction waits, so they stay stable until accepted.
    assign w_in_split   = (r_state == S_SPLIT);
    assign txn_valid_o  = w_in_split && (r_outstanding < MAX_OUT);
    assign txn_addr_o   = w_in_split ? r_cur_addr : '0;
    assign txn_len_o    = w_in_split ? w_len : 8'd0;
    assign txn_nbytes_o = w_in_split ? w_chunk[LenWidth-1:0] : '0;
    assign txn_last_o   = w_in_split && w_last;

    assign req_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign meta_valid_o = r_meta_valid;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign dbg_state_o  = r_state;

    assign w_txn_fire = txn_valid_o && txn_ready_i;
    assign w_done_dec = txn_done_i && (r_outstanding != '0);

    always_comb begin
        w_out_next = r_outstanding;
        if (w_txn_fire && !w_done_dec) begin
            w_out_next = r_outstanding + OW'(1);
        end else if (!w_txn_fire && w_done_dec) begin
            w_out_next = r_outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_meta_valid  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_cur_addr  <= req_addr_i;
                        r_remaining <= req_nbytes_i;
                        if (req_nbytes_i != '0) begin
                            r_state      <= S_META;
                            r_busy       <= 1'b1;
                            r_meta_valid <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_META: begin
                    if (meta_ready_i) begin
                        r_state      <= S_SPLIT;
                        r_meta_valid <= 1'b0;
                    end
                end
                S_SPLIT: begin
                    if (w_txn_fire) begin
                        r_cur_addr  <= r_cur_addr + AxiAddrWidth'(w_chunk);
                        r_remaining <= r_remaining - w_chunk[LenWidth-1:0];
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Looks at the post-update count so a final txn_done_i this cycle still closes the command.
                    if (w_out_next == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: directed address/boundary/reset cases plus randomized commands
// checked against a transaction-list model built from the splitting rules.
module tb_load_sequencer;

    localparam int AW = 64;
    localparam int LW = 32;
    localparam int BB = 64;
    localparam int MB = 16;
    localparam int MO = 2;
    localparam int TW = AW + 8 + LW + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [LW-1:0] req_nbytes_i = '0;
    logic          meta_valid_o;
    logic          meta_ready_i = 1'b0;
    logic          txn_valid_o;
    logic          txn_ready_i = 1'b0;
    logic [AW-1:0] txn_addr_o;
    logic [7:0]    txn_len_o;
    logic [LW-1:0] txn_nbytes_o;
    logic          txn_last_o;
    logic          txn_done_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    dbg_state_o;

    load_sequencer #(
        .AxiDataWidth  (512),
        .AxiAddrWidth  (AW),
        .MaxBurstBeats (MB),
        .MaxOutstanding(MO),
        .LenWidth      (LW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_nbytes_i(req_nbytes_i),
        .meta_valid_o(meta_valid_o),
        .meta_ready_i(meta_ready_i),
        .txn_valid_o (txn_valid_o),
        .txn_ready_i (txn_ready_i),
        .txn_addr_o  (txn_addr_o),
        .txn_len_o   (txn_len_o),
        .txn_nbytes_o(txn_nbytes_o),
        .txn_last_o  (txn_last_o),
        .txn_done_i  (txn_done_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail = 0;
    logic [TW-1:0] exp_q[$];
    int            inflight = 0;
    int            issued = 0;
    int            meta_cnt = 0;
    bit            auto_ds = 1'b0;
    logic          man_meta = 1'b0;
    logic          man_ready = 1'b0;
    logic          man_done = 1'b0;
    logic          pend = 1'b0;
    logic [TW-1:0] pend_fields = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the command, carving chunks by beat-window (and optional page) limits.
    function automatic int model_cmd(input logic [63:0] addr, input logic [31:0] nb);
        logic [63:0]     a;
        longint unsigned rem, off, lim, chunk, len;
        logic [7:0]      len8;
        logic [31:0]     c32;
        int              n;
        a = addr;
        rem = nb;
        n = 0;
        while (rem != 0) begin
            off = a % BB;
            lim = MB * BB - off;
`ifdef LOAD_SEQ_4K_BOUNDARY_EN
            if (4096 - (a % 4096) < lim) lim = 4096 - (a % 4096);
`endif
            chunk = (rem < lim) ? rem : lim;
            len = (off + chunk + BB - 1) / BB - 1;
            len8 = len[7:0];
            c32 = chunk[31:0];
            exp_q.push_back({a, len8, c32, (chunk == rem)});
            a = a + chunk;
            rem = rem - chunk;
            n++;
        end
        return n;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        logic [TW-1:0] cur_f;
        logic          fire;
        if (rst_i) begin
            inflight = 0;
            pend = 1'b0;
        end else begin
            cur_f = {txn_addr_o, txn_len_o, txn_nbytes_o, txn_last_o};
            fire = txn_valid_o && txn_ready_i;
            if (pend) begin
                check("txn_hold_valid", txn_valid_o, 1'b1);
                check("txn_hold_fields", cur_f, pend_fields);
            end
            if (inflight >= MO) check("outstanding_limit", txn_valid_o, 1'b0);
            if (fire) begin
                if (exp_q.size() == 0) check("txn_unexpected", exp_q.size(), 1);
                else check("txn_fields", cur_f, exp_q.pop_front());
                issued++;
            end
            if (meta_valid_o && meta_ready_i) meta_cnt++;
            pend = txn_valid_o && !txn_ready_i;
            pend_fields = cur_f;
            inflight = inflight + (fire ? 1 : 0) - ((txn_done_i && inflight > 0) ? 1 : 0);
        end
    end

    // ---------------- downstream driver ----------------
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (auto_ds) begin
                meta_ready_i = 1'($urandom_range(0, 1));
                txn_ready_i  = ($urandom_range(0, 3) != 0);
                txn_done_i   = (inflight > 0) && ($urandom_range(0, 2) == 0);
            end else begin
                meta_ready_i = man_meta;
                txn_ready_i  = man_ready;
                txn_done_i   = man_done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [63:0] addr, input logic [31:0] nb, output bit ok);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b1;
        req_addr_i = addr;
        req_nbytes_i = nb;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("req_accept", ok, 1'b1);
        if (ok) check("req_idle_not_busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_issued(input string tag, input int target);
        for (int i = 0; i < 300 && issued < target; i++) @(negedge clk_i);
        check(tag, issued >= target, 1'b1);
    endtask

    task automatic pulse_done();
        @(posedge clk_i);
        man_done = 1'b1;
        @(posedge clk_i);
        man_done = 1'b0;
    endtask

    // Last completion: done_o must be low in the txn_done_i cycle and high in the next.
    task automatic final_done_pulse(input string tag);
        @(posedge clk_i);
        man_done = 1'b1;
        @(negedge clk_i);
        check({tag, "_not_early"}, done_o, 1'b0);
        @(posedge clk_i);
        man_done = 1'b0;
        @(negedge clk_i);
        check({tag, "_done_pulse"}, done_o, 1'b1);
    endtask

    task automatic dir_cmd(input string tag, input logic [63:0] addr, input logic [31:0] nb,
                           input int n_txn);
        int m0, i0;
        bit ok;
        m0 = meta_cnt;
        i0 = issued;
        send_cmd(addr, nb, ok);
        wait_issued({tag, "_issue"}, i0 + n_txn);
        repeat (4) @(negedge clk_i);
        check({tag, "_txn_count"}, issued - i0, n_txn);
        check({tag, "_meta_count"}, meta_cnt - m0, 1);
        check({tag, "_no_early_done"}, done_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b1);
        repeat (n_txn - 1) pulse_done();
        final_done_pulse(tag);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_cmd(input logic [63:0] addr, input logic [31:0] nb);
        int  m0, i0, n_exp, lat;
        bit  ok, seen;
        exp_q.delete();
        m0 = meta_cnt;
        i0 = issued;
        n_exp = model_cmd(addr, nb);
        send_cmd(addr, nb, ok);
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                lat = i;
                break;
            end
        end
        check("cmd_done_seen", seen, 1'b1);
        check("cmd_txn_count", issued - i0, n_exp);
        check("cmd_meta_count", meta_cnt - m0, (nb != 0) ? 1 : 0);
        check("cmd_queue_empty", exp_q.size(), 0);
        check("cmd_done_not_busy", busy_o, 1'b0);
        if (nb == 0) check("zero_done_latency", lat, 1);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   m0, i0, quiet;
        bit   ok;
        logic [63:0] ra;
        logic [31:0] rn;

        #1;
        check("reset_outputs", {req_ready_o, meta_valid_o, txn_valid_o, busy_o, done_o,
                                txn_addr_o, txn_len_o, txn_nbytes_o, txn_last_o}, '0);
        check("reset_state", dbg_state_o, 2'd0);
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1 check("reset_release_ready", req_ready_o, 1'b1);

        man_meta = 1'b1;
        man_ready = 1'b1;

        // Aligned single burst
        exp_q.push_back({64'h1000, 8'd3, 32'd256, 1'b1});
        dir_cmd("r018", 64'h1000, 32'd256, 1);

        // Page-straddling command
`ifdef LOAD_SEQ_4K_BOUNDARY_EN
        exp_q.push_back({64'h0FC0, 8'd0, 32'd64, 1'b0});
        exp_q.push_back({64'h1000, 8'd0, 32'd64, 1'b1});
        dir_cmd("r019", 64'h0FC0, 32'd128, 2);
`else
        exp_q.push_back({64'h0FC0, 8'd1, 32'd128, 1'b1});
        dir_cmd("r019", 64'h0FC0, 32'd128, 1);
`endif

        // Unaligned short command spanning two beats
        exp_q.push_back({64'h10, 8'd1, 32'd100, 1'b1});
        dir_cmd("r021", 64'h10, 32'd100, 1);

        // Zero-byte command
        run_cmd(64'h1234, 32'd0);

        // Outstanding limit, then handshake and completion in the same cycle
        exp_q.delete();
        exp_q.push_back({64'h000, 8'd15, 32'd1024, 1'b0});
        exp_q.push_back({64'h400, 8'd15, 32'd1024, 1'b0});
        exp_q.push_back({64'h800, 8'd15, 32'd1024, 1'b0});
        exp_q.push_back({64'hC00, 8'd15, 32'd1024, 1'b1});
        m0 = meta_cnt;
        i0 = issued;
        send_cmd(64'h0, 32'd4096, ok);
        wait_issued("r020_first_two", i0 + 2);
        repeat (10) @(negedge clk_i);
        check("r020_issued_two", issued - i0, 2);
        check("r020_third_blocked", txn_valid_o, 1'b0);
        @(posedge clk_i);
        man_done = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        man_done = 1'b0;
        repeat (6) @(negedge clk_i);
        check("r020_issued_four", issued - i0, 4);
        check("r020_drain_hold", txn_valid_o, 1'b0);
        check("r020_meta", meta_cnt - m0, 1);
        pulse_done();
        final_done_pulse("r020");
        check("r020_queue_empty", exp_q.size(), 0);

        // Reset in the middle of splitting
        exp_q.delete();
        man_ready = 1'b0;
        send_cmd(64'h0, 32'd4096, ok);
        repeat (4) @(negedge clk_i);
        check("rst_pre_valid", txn_valid_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_outputs", {req_ready_o, meta_valid_o, txn_valid_o, busy_o, done_o,
                              txn_addr_o, txn_len_o, txn_nbytes_o, txn_last_o}, '0);
        check("rst_state", dbg_state_o, 2'd0);
        man_done = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1 check("rst_release_ready", req_ready_o, 1'b1);
        @(posedge clk_i);
        man_done = 1'b0;
        man_ready = 1'b1;
        quiet = 0;
        repeat (6) begin
            @(negedge clk_i);
            quiet = quiet + int'(done_o) + int'(busy_o) + int'(meta_valid_o) + int'(txn_valid_o);
        end
        check("rst_no_done_after", quiet, 0);
        check("rst_idle_state", dbg_state_o, 2'd0);
        exp_q.push_back({64'h1000, 8'd3, 32'd256, 1'b1});
        dir_cmd("post_rst", 64'h1000, 32'd256, 1);

        // Randomized commands with random downstream behaviour
        man_meta = 1'b0;
        man_ready = 1'b0;
        auto_ds = 1'b1;
        run_cmd(64'hFFFF_FFFF_FFFF_FF80, 32'd3000);
        run_cmd(64'h0000_0000_0000_0FF0, 32'd5000);
        for (int k = 0; k < 30; k++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) ra = {ra[63:12], 12'hFFF} - 64'($urandom_range(0, 200));
            if ($urandom_range(0, 5) == 0) rn = $urandom_range(0, 8);
            else rn = $urandom_range(1, 6000);
            run_cmd(ra, rn);
        end
        auto_ds = 1'b0;
        repeat (3) @(posedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
